// File: rtl/joy_db15_tx.sv
// joy_db15_tx: device-side responder for the DB15 serial joystick link.
// Emulates the parallel-in/serial-out chain sampled by a host DB15 reader.
//
// Ports:
//   clk         joystick clock (40-50 MHz)
//   reset       asynchronous, active-high
//   joystick1/2 player states, active-high, layout LS FEDCBAUDLR (bit0 = R)
//   cascade_in  async fill bit from a downstream chain (cascade builds only)
//   JOY_CLK     async shift clock from host, shift on rising edge
//   JOY_LOAD    async parallel load from host, active-low
//   JOY_DATA    serial data to host, active-low on wire, idle high
//   busy        high from load release until frame complete or abort
//   frame_done  one-cycle pulse when the last chain bit has been shifted
//   overrun     sticky, set by shift edges beyond the chain length
//
// Optional feature: define JOY_DB15_TX_CASCADE_EN to add cascade_in, whose
// synchronized value replaces the constant 1 fill bit on every shift.

module joy_db15_tx #(
    parameter int PLAYER_BITS = 12,
    parameter int SYNC_STAGES = 2
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [PLAYER_BITS-1:0] joystick1,
    input  logic [PLAYER_BITS-1:0] joystick2,
`ifdef JOY_DB15_TX_CASCADE_EN
    input  logic                   cascade_in,
`endif
    input  logic                   JOY_CLK,
    input  logic                   JOY_LOAD,
    output logic                   JOY_DATA,
    output logic                   busy,
    output logic                   frame_done,
    output logic                   overrun
);

    localparam int N  = 2 * PLAYER_BITS;
    localparam int CW = $clog2(N) + 1;

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        SHIFT,
        DONE
    } state_t;

    state_t                 state;
    logic [N-1:0]           sreg;
    logic [CW-1:0]          bit_cnt;
    logic [SYNC_STAGES-1:0] ck_sync;
    logic [SYNC_STAGES-1:0] ld_sync;
    logic                   ck_s;
    logic                   ld_s;
    logic                   ck_q;
    logic                   ck_rise;
    logic                   fill;
    logic [N-1:0]           load_val;
    logic [N-1:0]           shifted;

    // Pins idle high, so synchronizers and the edge history reset to 1
    // to avoid a spurious edge after reset.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ck_sync <= '1;
            ld_sync <= '1;
            ck_q    <= 1'b1;
        end else begin
            ck_sync <= {ck_sync[SYNC_STAGES-2:0], JOY_CLK};
            ld_sync <= {ld_sync[SYNC_STAGES-2:0], JOY_LOAD};
            ck_q    <= ck_s;
        end
    end

    assign ck_s    = ck_sync[SYNC_STAGES-1];
    assign ld_s    = ld_sync[SYNC_STAGES-1];
    assign ck_rise = ck_s & ~ck_q;

`ifdef JOY_DB15_TX_CASCADE_EN
    logic [SYNC_STAGES-1:0] cas_sync;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cas_sync <= '1;
        end else begin
            cas_sync <= {cas_sync[SYNC_STAGES-2:0], cascade_in};
        end
    end

    assign fill = cas_sync[SYNC_STAGES-1];
`else
    assign fill = 1'b1;
`endif

    // Wire level is active-low: a pressed button shifts out as 0.
    assign load_val = ~{joystick2, joystick1};
    assign shifted  = {fill, sreg[N-1:1]};

    // sreg is the output register, so JOY_DATA moves SYNC_STAGES+1
    // cycles after a pin edge.
    assign JOY_DATA = sreg[0];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            sreg       <= '1;
            bit_cnt    <= '0;
            busy       <= 1'b0;
            frame_done <= 1'b0;
            overrun    <= 1'b0;
        end else begin
            frame_done <= 1'b0;
            // Load dominates: it aborts any frame and masks a
            // simultaneous shift edge.
            if (!ld_s) begin
                state   <= LOAD;
                sreg    <= load_val;
                bit_cnt <= '0;
                busy    <= 1'b0;
            end else begin
                unique case (state)
                    IDLE: begin
                        if (ck_rise) begin
                            sreg <= shifted;
                        end
                    end
                    LOAD: begin
                        // Still in LOAD with ld_s high: load released.
                        state   <= SHIFT;
                        busy    <= 1'b1;
                        bit_cnt <= '0;
                    end
                    SHIFT: begin
                        if (ck_rise) begin
                            sreg    <= shifted;
                            bit_cnt <= bit_cnt + CW'(1);
                            if (bit_cnt == CW'(N - 1)) begin
                                frame_done <= 1'b1;
                                busy       <= 1'b0;
                                state      <= DONE;
                            end
                        end
                    end
                    DONE: begin
                        if (ck_rise) begin
                            sreg    <= shifted;
                            overrun <= 1'b1;
                        end
                    end
                    default: begin
                        state <= IDLE;
                    end
                endcase
            end
        end
    end

endmodule
